// File: rtl/gemm.sv
// GEMM engine: O = F x X over three internal single-port-read SRAMs.
// Ports: clk, rst_n (sync active-high), start, k/m/n dims in,
// rd_addr/rd_data result readback, busy/done/err status.
// Optional macro GEMM_SATURATE_EN: saturate stored results to WIDTH.

module gemm_sram #(
    parameter int W  = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end
endmodule

module gemm #(
    parameter int WIDTH           = 16,
    parameter int SRAM_ADDR_WIDTH = 10,
    parameter int I               = 20,
    parameter int J               = 20
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                k,
    input  logic [15:0]                m,
    input  logic [15:0]                n,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int AW    = SRAM_ADDR_WIDTH;
    localparam int ACC_W = 2*WIDTH + $clog2(I);
    localparam logic [32:0] LIMIT = 33'(1) << AW;
    localparam logic signed [ACC_W-1:0] SMAX = (ACC_W'(1) << (WIDTH-1)) - 1;
    localparam logic signed [ACC_W-1:0] SMIN = -(ACC_W'(1) << (WIDTH-1));

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_MAC, S_WRITE, S_DONE
    } state_t;

    state_t                  state_q;
    logic [15:0]             k_q, m_q, n_q;
    logic [15:0]             r_q, c_q, t_q;
    logic [AW-1:0]           f_ptr_q, x_ptr_q, o_ptr_q;
    logic [AW-1:0]           row_base_q, col_base_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    busy_q, done_q, err_q;

    logic [WIDTH-1:0] f_rd, x_rd;
    logic [WIDTH-1:0] res;
    logic             o_we;

    gemm_sram #(.W(WIDTH), .AW(AW)) sram_filters (
        .clk(clk), .rst(rst_n), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(f_ptr_q), .rdata(f_rd)
    );

    gemm_sram #(.W(WIDTH), .AW(AW)) sram_ifmaps (
        .clk(clk), .rst(rst_n), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(x_ptr_q), .rdata(x_rd)
    );

    gemm_sram #(.W(WIDTH), .AW(AW)) sram_ofmaps (
        .clk(clk), .rst(rst_n), .we(o_we), .waddr(o_ptr_q), .wdata(res),
        .raddr(rd_addr), .rdata(rd_data)
    );

    // Dimension legality
    logic [31:0] mk, kn, mn;
    logic        bad;
    assign mk  = 32'(m_q) * 32'(k_q);
    assign kn  = 32'(k_q) * 32'(n_q);
    assign mn  = 32'(m_q) * 32'(n_q);
    assign bad = (k_q == 16'd0) || (m_q == 16'd0) || (n_q == 16'd0) ||
                 (32'(k_q) > 32'(I)) || (32'(n_q) > 32'(J)) ||
                 ({1'b0, mk} > LIMIT) || ({1'b0, kn} > LIMIT) ||
                 ({1'b0, mn} > LIMIT);

    logic signed [2*WIDTH-1:0] prod;
    assign prod = $signed(f_rd) * $signed(x_rd);

`ifdef GEMM_SATURATE_EN
    always_comb begin
        if (acc_q > SMAX)      res = SMAX[WIDTH-1:0];
        else if (acc_q < SMIN) res = SMIN[WIDTH-1:0];
        else                   res = acc_q[WIDTH-1:0];
    end
`else
    assign res = acc_q[WIDTH-1:0];
`endif

    assign o_we = (state_q == S_WRITE);

    // Next element bases, column-fastest traversal
    logic          last_col, last_row;
    logic [AW-1:0] nxt_row_base, nxt_col_base;
    assign last_col     = (c_q == n_q - 16'd1);
    assign last_row     = (r_q == m_q - 16'd1);
    assign nxt_row_base = last_col ? row_base_q + k_q[AW-1:0] : row_base_q;
    assign nxt_col_base = last_col ? '0 : col_base_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            r_q        <= '0;
            c_q        <= '0;
            t_q        <= '0;
            f_ptr_q    <= '0;
            x_ptr_q    <= '0;
            o_ptr_q    <= '0;
            row_base_q <= '0;
            col_base_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        k_q     <= k;
                        m_q     <= m;
                        n_q     <= n;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        r_q        <= '0;
                        c_q        <= '0;
                        t_q        <= '0;
                        f_ptr_q    <= '0;
                        x_ptr_q    <= '0;
                        o_ptr_q    <= '0;
                        row_base_q <= '0;
                        col_base_q <= '0;
                        acc_q      <= '0;
                        state_q    <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Read data lags the address by one cycle
                    if (t_q != 16'd0) acc_q <= acc_q + ACC_W'(prod);
                    f_ptr_q <= f_ptr_q + AW'(1);
                    x_ptr_q <= x_ptr_q + n_q[AW-1:0];
                    t_q     <= t_q + 16'd1;
                    if (t_q == k_q) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    o_ptr_q    <= o_ptr_q + AW'(1);
                    row_base_q <= nxt_row_base;
                    col_base_q <= nxt_col_base;
                    f_ptr_q    <= nxt_row_base;
                    x_ptr_q    <= nxt_col_base;
                    t_q        <= '0;
                    acc_q      <= '0;
                    if (last_col) begin
                        c_q <= '0;
                        r_q <= r_q + 16'd1;
                    end else begin
                        c_q <= c_q + 16'd1;
                    end
                    if (last_col && last_row) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_MAC;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_gemm.sv
// Scoreboard bench for gemm: driver queues expected done/err/readback
// events, a negedge monitor pops and compares them.

module tb_gemm;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] k = '0, m = '0, n = '0;
    logic [9:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy, done, err;

    gemm dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .k(k), .m(m), .n(n),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rd_req = 1'b0;
    logic rd_pend = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_pend <= rd_req;
    end

    task automatic pop_check(input int kind, input int val, input string nm);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got %0d", nm, val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL %s got kind %0d val %0h expected kind %0d val %0h",
                         nm, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done)    pop_check(0, cyc, "done_cycle");
        if (err)     pop_check(1, cyc, "err_cycle");
        if (rd_pend) pop_check(2, int'(rd_data), "rd_data");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input int kk, input int mm, input int nn,
                       input int lat, input int kind);
        @(negedge clk);
        k = 16'(kk);
        m = 16'(mm);
        n = 16'(nn);
        start = 1'b1;
        if (lat > 0) sbq.push_back('{kind, cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rd(input int addr, input int exp);
        @(negedge clk);
        rd_addr = 10'(addr);
        rd_req = 1'b1;
        sbq.push_back('{2, exp});
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic drain(input int budget);
        int w = 0;
        while (sbq.size() != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending %0d expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    function automatic int model_out(input longint s);
`ifdef GEMM_SATURATE_EN
        if (s > 32767)  return 32'h7FFF;
        if (s < -32768) return 32'h8000;
`endif
        return int'(s & 64'hFFFF);
    endfunction

    int f[12][18];
    int x[18][4];

    initial begin
        longint s;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        rst_n = 1'b0;
        @(negedge clk);

        // 1x1x1: 3 * -2
        dut.sram_filters.mem[0] = 16'h0003;
        dut.sram_ifmaps.mem[0]  = 16'hFFFE;
        run(1, 1, 1, 5, 0);
        drain(50);
        rd(0, 32'hFFFA);
        drain(10);

        // Rejected starts
        run(21, 1, 1, 2, 1);
        drain(20);
        chk("err_k_busy", int'(busy), 0);
        run(1, 0, 1, 2, 1);
        drain(20);
        chk("err_m_busy", int'(busy), 0);
        rd(0, 32'hFFFA);
        drain(10);

        // Overflow handling, positive then negative
        dut.sram_filters.mem[0] = 16'h7FFF;
        dut.sram_filters.mem[1] = 16'h7FFF;
        dut.sram_ifmaps.mem[0]  = 16'h7FFF;
        dut.sram_ifmaps.mem[1]  = 16'h7FFF;
        run(2, 1, 1, 6, 0);
        drain(50);
`ifdef GEMM_SATURATE_EN
        rd(0, 32'h7FFF);
`else
        rd(0, 32'h0002);
`endif
        drain(10);
        dut.sram_filters.mem[0] = 16'h8000;
        dut.sram_filters.mem[1] = 16'h8000;
        run(2, 1, 1, 6, 0);
        drain(50);
`ifdef GEMM_SATURATE_EN
        rd(0, 32'h8000);
`else
        rd(0, 32'h0000);
`endif
        drain(10);

        // Full-size run K=18 M=12 N=4
        for (int r = 0; r < 12; r++)
            for (int t = 0; t < 18; t++) begin
                f[r][t] = int'($urandom_range(0, 65535)) - 32768;
                dut.sram_filters.mem[r*18+t] = 16'(f[r][t]);
            end
        for (int t = 0; t < 18; t++)
            for (int c = 0; c < 4; c++) begin
                x[t][c] = int'($urandom_range(0, 65535)) - 32768;
                dut.sram_ifmaps.mem[t*4+c] = 16'(x[t][c]);
            end
        run(18, 12, 4, 962, 0);
        drain(1200);
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int t = 0; t < 18; t++)
                    s += longint'(f[r][t]) * longint'(x[t][c]);
                rd(r*4+c, model_out(s));
            end
        drain(20);

        // Ignored second start, then reset mid-run
        run(18, 12, 4, 0, 0);
        repeat (10) @(negedge clk);
        run(1, 1, 1, 0, 0);
        repeat (50) @(negedge clk);
        chk("midrun_busy", int'(busy), 1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (5) @(negedge clk);
        chk("abort_idle_busy", int'(busy), 0);

        dut.sram_filters.mem[0] = 16'h0003;
        dut.sram_ifmaps.mem[0]  = 16'hFFFE;
        run(1, 1, 1, 5, 0);
        drain(50);
        rd(0, 32'hFFFA);
        drain(10);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gemm.md
GEMM -- requirements
Module: gemm

Interface
REQ-001 Parameter WIDTH, default 16: operand and stored-result width, signed two's complement.
REQ-002 Parameter SRAM_ADDR_WIDTH, default 10: each internal SRAM has 2**SRAM_ADDR_WIDTH words of WIDTH bits.
REQ-003 Parameter I, default 20: maximum supported k (reduction depth).
REQ-004 Parameter J, default 20: maximum supported n (output columns).
REQ-005 Clock and reset: one clock, clk; reset is synchronous and active-high, port rst_n (name kept for codebase compatibility, polarity active-high).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle request to begin a GEMM run.
REQ-009 k  input  16  reduction dimension K, sampled when start is accepted.
REQ-010 m  input  16  output row count M, sampled when start is accepted.
REQ-011 n  input  16  output column count N, sampled when start is accepted.
REQ-012 rd_addr  input  SRAM_ADDR_WIDTH  result SRAM read address.
REQ-013 rd_data  output  WIDTH  result word, registered, one-cycle latency after rd_addr.
REQ-014 busy  output  1  high while a run is in progress.
REQ-015 done  output  1  one-cycle pulse when a run completes.
REQ-016 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 Internal instances sram_filters, sram_ifmaps, sram_ofmaps SHALL each contain a reg array named mem, hierarchically writable for preload (e.g. $readmemh).
REQ-018 Layout: F[r][c] at sram_filters address r*K+c (M x K); X[r][c] at sram_ifmaps address r*N+c (K x N); O[r][c] at sram_ofmaps address r*N+c.
REQ-019 Function: O[r][c] = sum over t=0..K-1 of F[r][t]*X[t][c], signed products, accumulator 2*WIDTH+clog2(I) bits, stored as low WIDTH bits (wrap) unless REQ-031.
REQ-020 FSM states IDLE, CHECK, MAC, WRITE, DONE; reset state IDLE.
REQ-021 IDLE: start=1 latches k,m,n and enters CHECK; busy asserts the next cycle.
REQ-022 CHECK (1 cycle): if k=0, m=0, n=0, k>I, n>J, m*k, k*n or m*n exceeds 2**SRAM_ADDR_WIDTH, pulse err and return to IDLE without writing; else clear row/col indices and enter MAC.
REQ-023 MAC: one MAC per cycle over t=0..K-1 with one-cycle SRAM read latency, occupying K+1 cycles per output element; then WRITE (1 cycle) stores O[r][c].
REQ-024 Element order column-fastest (c increments, then r); after last element enter DONE.
REQ-025 DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE; total run = 2 + M*N*(K+2) cycles from start to done.
REQ-026 start while busy SHALL be ignored; start and done in the same cycle: start ignored.
REQ-027 rd_data reads sram_ofmaps at any time, including during a run (may return stale data).
REQ-028 sram_filters and sram_ifmaps SHALL never be written by the block.

Reset
REQ-029 Reset: state IDLE, busy=0, done=0, err=0, rd_data=0, indices and accumulator cleared; SRAM contents unchanged.
REQ-030 Reset mid-run aborts immediately with no done pulse; already-written results remain.

Configuration
REQ-031 Macro GEMM_SATURATE_EN: defined -> stored result saturates to signed WIDTH range (e.g. 16'h7FFF / 16'h8000); undefined -> low WIDTH bits wrap.

Verification
REQ-032 K=18, M=12, N=4, random F, X preloaded -> done after 2+48*20=962 cycles; all 48 O words match reference model.
REQ-033 K=1, M=1, N=1, F[0][0]=3, X[0][0]=-2 -> done after 5 cycles, O[0][0]=16'hFFFA.
REQ-034 k=21 (or m=0) -> err pulse 2 cycles after start, no done, sram_ofmaps unchanged, busy low.
REQ-035 K=2, F row all 16'h7FFF, X all 16'h7FFF -> O=16'h0002 without macro, 16'h7FFF with GEMM_SATURATE_EN.
REQ-036 Second start while busy, then rst_n=1 mid-run -> second start ignored; after reset busy=0, no done, new start runs normally.
